// File: rtl/gprs_pkg.sv
// Shared GPR widths, the writeback request record and the arbiter grant encoding.
// Used by gprs_wb_arbiter; the pending-register helper only matters with GPRS_WB_PENDING_EN.
package gprs_pkg;

  localparam int REG_W    = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } wb_req_t;

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/gprs_wb_arbiter_if.sv
// Bundle of the two writeback request channels and the GPR write port.
// The pending vector exists only when GPRS_WB_PENDING_EN is defined.
interface gprs_wb_arbiter_if;
  import gprs_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_ws;
  logic [REG_W-1:0]  req0_wd;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_ws;
  logic [REG_W-1:0]  req1_wd;
  logic [ADDR_W-1:0] ws;
  logic [REG_W-1:0]  wd;
  logic              we;
`ifdef GPRS_WB_PENDING_EN
  logic [NUM_REGS-1:0] pending;

  modport master (
    output req0_valid, req0_ws, req0_wd, req1_valid, req1_ws, req1_wd,
    input  req0_ready, req1_ready, ws, wd, we, pending
  );

  modport slave (
    input  req0_valid, req0_ws, req0_wd, req1_valid, req1_ws, req1_wd,
    output req0_ready, req1_ready, ws, wd, we, pending
  );
`else
  modport master (
    output req0_valid, req0_ws, req0_wd, req1_valid, req1_ws, req1_wd,
    input  req0_ready, req1_ready, ws, wd, we
  );

  modport slave (
    input  req0_valid, req0_ws, req0_wd, req1_valid, req1_ws, req1_wd,
    output req0_ready, req1_ready, ws, wd, we
  );
`endif

endinterface

// File: rtl/wb_fifo.sv
// Small circular FIFO of writeback requests; ready comes only from the registered count.
// Per-slot valid/address taps are exported only with GPRS_WB_PENDING_EN.
module wb_fifo
  import gprs_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  output logic    ready,
  input  wb_req_t din,
  input  logic    pop,
  output logic    empty,
  output wb_req_t dout
`ifdef GPRS_WB_PENDING_EN
  ,
  output logic [DEPTH-1:0]             entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0] entry_addr
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign ready   = (count < (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign push_ok = push && ready;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: slot contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

`ifdef GPRS_WB_PENDING_EN
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset      = '0;
    entry_valid = '0;
    entry_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset         = PTR_W'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, offset} < count);
      entry_addr[i]  = mem[i].addr;
    end
  end
`endif

endmodule

// File: rtl/gprs_wb_arbiter.sv
// Round-robin merge of ALU and load writebacks onto the single GPR write port.
// Define GPRS_WB_PENDING_EN to add the per-register pending vector for RAW stalls.
module gprs_wb_arbiter
  import gprs_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  gprs_wb_arbiter_if.slave   bus
);

  wb_req_t           din0;
  wb_req_t           din1;
  wb_req_t           dout0;
  wb_req_t           dout1;
  logic              empty0;
  logic              empty1;
  logic              pop0;
  logic              pop1;
  grant_t            last_grant;
  logic              we_r;
  logic [ADDR_W-1:0] ws_r;
  logic [REG_W-1:0]  wd_r;

  assign din0 = '{addr: bus.req0_ws, data: bus.req0_wd};
  assign din1 = '{addr: bus.req1_ws, data: bus.req1_wd};

`ifdef GPRS_WB_PENDING_EN
  logic [DEPTH-1:0]             valid0;
  logic [DEPTH-1:0]             valid1;
  logic [DEPTH-1:0][ADDR_W-1:0] addr0;
  logic [DEPTH-1:0][ADDR_W-1:0] addr1;
  logic [NUM_REGS-1:0]          pending_c;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk         (clk),
    .reset       (reset),
    .push        (bus.req0_valid),
    .ready       (bus.req0_ready),
    .din         (din0),
    .pop         (pop0),
    .empty       (empty0),
    .dout        (dout0)
`ifdef GPRS_WB_PENDING_EN
    ,
    .entry_valid (valid0),
    .entry_addr  (addr0)
`endif
  );

  wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk         (clk),
    .reset       (reset),
    .push        (bus.req1_valid),
    .ready       (bus.req1_ready),
    .din         (din1),
    .pop         (pop1),
    .empty       (empty1),
    .dout        (dout1)
`ifdef GPRS_WB_PENDING_EN
    ,
    .entry_valid (valid1),
    .entry_addr  (addr1)
`endif
  );

  // When both FIFOs hold work, the one not served last wins.
  always_comb begin
    pop0 = 1'b0;
    pop1 = 1'b0;
    if (!empty0 && !empty1) begin
      if (last_grant == GRANT_REQ1) pop0 = 1'b1;
      else                          pop1 = 1'b1;
    end else if (!empty0) begin
      pop0 = 1'b1;
    end else if (!empty1) begin
      pop1 = 1'b1;
    end
  end

  // Starting as "req1 served last" makes req0 win the first contested cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_REQ1;
    end else if (pop0) begin
      last_grant <= GRANT_REQ0;
    end else if (pop1) begin
      last_grant <= GRANT_REQ1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_r <= 1'b0;
      ws_r <= '0;
      wd_r <= '0;
    end else begin
      we_r <= pop0 || pop1;
      if (pop0) begin
        ws_r <= dout0.addr;
        wd_r <= dout0.data;
      end else if (pop1) begin
        ws_r <= dout1.addr;
        wd_r <= dout1.data;
      end
    end
  end

  assign bus.we = we_r;
  assign bus.ws = ws_r;
  assign bus.wd = wd_r;

`ifdef GPRS_WB_PENDING_EN
  always_comb begin
    pending_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid0[i]) pending_c = pending_c | reg_onehot(addr0[i]);
      if (valid1[i]) pending_c = pending_c | reg_onehot(addr1[i]);
    end
    if (we_r) pending_c = pending_c | reg_onehot(ws_r);
  end

  assign bus.pending = pending_c;
`endif

endmodule

// File: tb/tb_gprs_wb_arbiter.sv
// Scoreboard bench for gprs_wb_arbiter: a queue-based model predicts every GPR write.
// Pending-vector checks are compiled in when GPRS_WB_PENDING_EN is defined.
module tb_gprs_wb_arbiter;
  import gprs_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gprs_wb_arbiter_if bus ();

  gprs_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: FIFO contents as queues, last-served requester, output stage.
  wb_req_t m_q0[$];
  wb_req_t m_q1[$];
  wb_req_t exp_q[$];
  int      m_last = 1;
  logic    m_we = 1'b0;
  wb_req_t m_out = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin : model
    bit acc0;
    bit acc1;
    int g;
    if (reset) begin
      m_q0.delete();
      m_q1.delete();
      exp_q.delete();
      m_last = 1;
      m_we   = 1'b0;
      m_out  = '0;
    end else begin
      acc0 = bus.req0_valid && (m_q0.size() < DEPTH);
      acc1 = bus.req1_valid && (m_q1.size() < DEPTH);
      g = -1;
      if (m_q0.size() > 0 && m_q1.size() > 0) g = (m_last == 1) ? 0 : 1;
      else if (m_q0.size() > 0)               g = 0;
      else if (m_q1.size() > 0)               g = 1;
      m_we = (g >= 0);
      if (g == 0) m_out = m_q0.pop_front();
      if (g == 1) m_out = m_q1.pop_front();
      if (g >= 0) begin
        m_last = g;
        exp_q.push_back(m_out);
      end
      if (acc0) m_q0.push_back('{addr: bus.req0_ws, data: bus.req0_wd});
      if (acc1) m_q1.push_back('{addr: bus.req1_ws, data: bus.req1_wd});
    end
  end

  always @(negedge clk) begin : monitor
    wb_req_t e;
`ifdef GPRS_WB_PENDING_EN
    logic [NUM_REGS-1:0] pend;
`endif
    checkOutput("we", 32'(bus.we), 32'(m_we));
    if (bus.we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write actual=ws%0d/wd%0h required=none at %0t",
                 bus.ws, bus.wd, $time);
      end else begin
        e = exp_q.pop_front();
        checkOutput("ws", 32'(bus.ws), 32'(e.addr));
        checkOutput("wd", 32'(bus.wd), 32'(e.data));
      end
    end else begin
      checkOutput("ws_hold", 32'(bus.ws), 32'(m_out.addr));
      checkOutput("wd_hold", 32'(bus.wd), 32'(m_out.data));
    end
    checkOutput("ready0", 32'(bus.req0_ready), 32'(m_q0.size() < DEPTH));
    checkOutput("ready1", 32'(bus.req1_ready), 32'(m_q1.size() < DEPTH));
`ifdef GPRS_WB_PENDING_EN
    pend = '0;
    foreach (m_q0[i]) pend[m_q0[i].addr] = 1'b1;
    foreach (m_q1[i]) pend[m_q1[i].addr] = 1'b1;
    if (m_we) pend[m_out.addr] = 1'b1;
    checkOutput("pending", 32'(bus.pending), 32'(pend));
`endif
  end

  // Drives one cycle of requests; entered and left just after a rising edge.
  task automatic applyStimulus(input logic v0, input logic [ADDR_W-1:0] a0, input logic [REG_W-1:0] d0,
                               input logic v1, input logic [ADDR_W-1:0] a1, input logic [REG_W-1:0] d1);
    bus.req0_valid = v0;
    bus.req0_ws    = a0;
    bus.req0_wd    = d0;
    bus.req1_valid = v1;
    bus.req1_ws    = a1;
    bus.req1_wd    = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic pulseReset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_ws    = '0;
    bus.req0_wd    = '0;
    bus.req1_valid = 1'b0;
    bus.req1_ws    = '0;
    bus.req1_wd    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      checkOutput("t1_we_idle", 32'(bus.we), 32'd0);
      checkOutput("t1_ready0", 32'(bus.req0_ready), 32'd1);
      checkOutput("t1_ready1", 32'(bus.req1_ready), 32'd1);
    end

    // Single ALU write: visible exactly two cycles after the push cycle
    applyStimulus(1'b1, 3'd3, 16'hBEEF, 1'b0, '0, '0);
    checkOutput("t2_we_c1", 32'(bus.we), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("t2_we_c2", 32'(bus.we), 32'd1);
    checkOutput("t2_ws_c2", 32'(bus.ws), 32'd3);
    checkOutput("t2_wd_c2", 32'(bus.wd), 32'hBEEF);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("t2_we_c3", 32'(bus.we), 32'd0);
    checkOutput("t2_ws_hold", 32'(bus.ws), 32'd3);

    // Both requesters streaming: alternation starting with req0
    pulseReset();
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, ADDR_W'(i), REG_W'(16'h1000 + i), 1'b1, ADDR_W'(7 - i), REG_W'(16'h2000 + i));
    idle(8);

    // FIFO1 fills, then resumes accepting after its first pop; reset mid-burst
    pulseReset();
    applyStimulus(1'b1, 3'd1, 16'hA000, 1'b1, 3'd2, 16'hB000);
    checkOutput("t4_ready1_e0", 32'(bus.req1_ready), 32'd1);
    applyStimulus(1'b1, 3'd1, 16'hA001, 1'b1, 3'd2, 16'hB001);
    checkOutput("t4_ready1_full", 32'(bus.req1_ready), 32'd0);
    applyStimulus(1'b1, 3'd1, 16'hA002, 1'b1, 3'd2, 16'hB002);
    checkOutput("t4_ready1_resume", 32'(bus.req1_ready), 32'd1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    checkOutput("t5_we_async", 32'(bus.we), 32'd0);
    checkOutput("t5_ws_async", 32'(bus.ws), 32'd0);
    checkOutput("t5_ready0_async", 32'(bus.req0_ready), 32'd1);
    checkOutput("t5_ready1_async", 32'(bus.req1_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
      checkOutput("t5_no_stale_we", 32'(bus.we), 32'd0);
    end

`ifdef GPRS_WB_PENDING_EN
    // Pending bit tracks a load write from acceptance through its write cycle
    checkOutput("t6_pending_before", 32'(bus.pending[5]), 32'd0);
    applyStimulus(1'b0, '0, '0, 1'b1, 3'd5, 16'h5555);
    checkOutput("t6_pending_fifo", 32'(bus.pending[5]), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("t6_pending_we", 32'(bus.pending[5]), 32'd1);
    checkOutput("t6_we", 32'(bus.we), 32'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("t6_pending_clear", 32'(bus.pending[5]), 32'd0);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 1)), ADDR_W'($urandom), REG_W'($urandom),
                    1'($urandom_range(0, 1)), ADDR_W'($urandom), REG_W'($urandom));
    idle(10);
    checkOutput("drain_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
